mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 62 ++++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared CPU defines for the memory stage: load/store funct3 codes, the
// memory FSM state encoding and small helpers for byte-lane handling.
package mem_stage_pkg;

  // funct3 codes for loads and stores (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Byte enables for an access of the given size at the given lane
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the size allows
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // True when the low address bits break natural alignment for the size
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3[1:0])
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Low address bits rounded down to natural alignment for the size
  function automatic logic [1:0] align_addr_lo(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] a;
    case (f3[1:0])
      2'b01:   a = {lo[1], 1'b0};
      2'b10:   a = 2'b00;
      default: a = lo;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int DMEM_ADDR_W = 32
);
  logic                   dmem_req;
  logic                   dmem_we;
  logic [DMEM_ADDR_W-1:0] dmem_addr;
  logic [3:0]             dmem_be;
  logic [31:0]            dmem_wdata;
  logic                   dmem_gnt;
  logic                   dmem_rvalid;
  logic [31:0]            dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane selection and sign/zero extension for the memory stage.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend to 32 bits by size and sign
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    data_o  = shifted;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      F3_W:    data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the dual-issue pipeline: issue A may load/store over the
// data bus, issue B is ALU-only and moves in lockstep with A.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently forcing natural alignment.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ia_alu_out,
  input  logic [31:0] ia_rs2_data,
  input  logic [4:0]  ia_rd_addr,
  input  logic        ia_reg_write,
  input  logic        ia_mem_read,
  input  logic        ia_mem_write,
  input  logic [2:0]  ia_funct3,
  input  logic [31:0] ib_alu_out,
  input  logic [4:0]  ib_rd_addr,
  input  logic        ib_reg_write,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic [31:0] oa_wb_data,
  output logic [4:0]  oa_rd_addr,
  output logic        oa_reg_write,
  output logic [31:0] ob_wb_data,
  output logic [4:0]  ob_rd_addr,
  output logic        ob_reg_write,
  output logic        oa_misalign
);

  mem_state_e             state_q;
  logic                   hold_we_q;
  logic [DMEM_ADDR_W-1:0] hold_addr_q;
  logic [3:0]             hold_be_q;
  logic [31:0]            hold_wdata_q;
  logic [2:0]             hold_funct3_q;
  logic [1:0]             hold_addr_lo_q;

  logic [31:0] oa_wb_data_q, ob_wb_data_q;
  logic [4:0]  oa_rd_addr_q, ob_rd_addr_q;
  logic        oa_reg_write_q, ob_reg_write_q, oa_misalign_q;

  logic        mem_op_raw, mem_op, misaligned, op_active;
  logic [1:0]  addr_lo_eff;
  logic [31:0] req_addr;
  logic        in_req, req_is_store, granted, store_done, load_done;
  logic [31:0] load_data;

  assign mem_op_raw = ia_mem_read | ia_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned  = mem_op_raw & is_misaligned(ia_funct3, ia_alu_out[1:0]);
  assign addr_lo_eff = ia_alu_out[1:0];
`else
  assign misaligned  = 1'b0;
  assign addr_lo_eff = align_addr_lo(ia_funct3, ia_alu_out[1:0]);
`endif

  assign mem_op    = mem_op_raw & ~misaligned;
  assign req_addr  = {ia_alu_out[31:2], addr_lo_eff};
  assign in_req    = (state_q == ST_REQ);
  assign op_active = (state_q != ST_IDLE) | mem_op;

  // While in REQ the bus is driven from the captured copy so it cannot move before the grant
  assign dmem.dmem_req   = rst_n & (((state_q == ST_IDLE) & mem_op) | in_req);
  assign dmem.dmem_we    = in_req ? hold_we_q    : ia_mem_write;
  assign dmem.dmem_addr  = in_req ? hold_addr_q  : req_addr[DMEM_ADDR_W-1:0];
  assign dmem.dmem_be    = in_req ? hold_be_q    : byte_enable(ia_funct3, addr_lo_eff);
  assign dmem.dmem_wdata = in_req ? hold_wdata_q : store_wdata(ia_funct3, ia_rs2_data);

  assign req_is_store = in_req ? hold_we_q : ia_mem_write;
  assign granted      = dmem.dmem_req & dmem.dmem_gnt;
  assign store_done   = granted & req_is_store;
  assign load_done    = (state_q == ST_WAIT) & dmem.dmem_rvalid;
  assign mem_stall    = rst_n & op_active & ~(store_done | load_done);

  mem_stage_load_align load_align (
    .rdata_i   (dmem.dmem_rdata),
    .addr_lo_i (hold_addr_lo_q),
    .funct3_i  (hold_funct3_q),
    .data_o    (load_data)
  );

  // Bus FSM: issue the request, hold it until granted, then wait for load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hold_we_q      <= 1'b0;
      hold_addr_q    <= '0;
      hold_be_q      <= 4'h0;
      hold_wdata_q   <= 32'h0;
      hold_funct3_q  <= 3'b000;
      hold_addr_lo_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            hold_we_q      <= ia_mem_write;
            hold_addr_q    <= req_addr[DMEM_ADDR_W-1:0];
            hold_be_q      <= byte_enable(ia_funct3, addr_lo_eff);
            hold_wdata_q   <= store_wdata(ia_funct3, ia_rs2_data);
            hold_funct3_q  <= ia_funct3;
            hold_addr_lo_q <= addr_lo_eff;
            if (dmem.dmem_gnt) begin
              state_q <= ia_mem_write ? ST_IDLE : ST_WAIT;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem.dmem_gnt) begin
            state_q <= hold_we_q ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rvalid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB buffer: bubbles out both issues while stalled, otherwise advances A and B together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oa_wb_data_q   <= 32'h0;
      oa_rd_addr_q   <= 5'd0;
      oa_reg_write_q <= 1'b0;
      ob_wb_data_q   <= 32'h0;
      ob_rd_addr_q   <= 5'd0;
      ob_reg_write_q <= 1'b0;
      oa_misalign_q  <= 1'b0;
    end else begin
      oa_misalign_q <= misaligned & (state_q == ST_IDLE);
      if (mem_stall) begin
        oa_reg_write_q <= 1'b0;
        ob_reg_write_q <= 1'b0;
      end else begin
        oa_wb_data_q   <= load_done ? load_data : ia_alu_out;
        oa_rd_addr_q   <= ia_rd_addr;
        oa_reg_write_q <= ia_reg_write & ~misaligned;
        ob_wb_data_q   <= ib_alu_out;
        ob_rd_addr_q   <= ib_rd_addr;
        ob_reg_write_q <= ib_reg_write;
      end
    end
  end

  assign oa_wb_data   = oa_wb_data_q;
  assign oa_rd_addr   = oa_rd_addr_q;
  assign oa_reg_write = oa_reg_write_q;
  assign ob_wb_data   = ob_wb_data_q;
  assign ob_rd_addr   = ob_rd_addr_q;
  assign ob_reg_write = ob_reg_write_q;
  assign oa_misalign  = oa_misalign_q;

endmodule
